// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for seq_detect: valid/ready word intake,
// one-word holding buffer, one payload bit per clock on dout.
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             bit_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q,     state_n;
    logic [WIDTH-1:0] shreg_q,     shreg_n;
    logic [WIDTH-1:0] hold_q,      hold_n;
    logic             hold_full_q, hold_full_n;
    logic [CW-1:0]    cnt_q,       cnt_n;
    logic             dout_q,      dout_n;
    logic             bit_valid_q, bit_valid_n;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;
    logic             head;

    always_comb begin
        state_n     = state_q;
        shreg_n     = shreg_q;
        hold_n      = hold_q;
        hold_full_n = hold_full_q;
        cnt_n       = cnt_q;
        accept      = data_valid && !hold_full_q;
        last_bit    = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        shifted     = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SHIFT;
                    shreg_n = data_in;
                    cnt_n   = '0;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    // Held word takes priority; an accept is impossible while hold is full.
                    if (hold_full_q) begin
                        shreg_n     = hold_q;
                        hold_full_n = 1'b0;
                        cnt_n       = '0;
                    end else if (accept) begin
                        shreg_n = data_in;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    shreg_n = shifted;
                    cnt_n   = cnt_q + CW'(1);
                    if (accept) begin
                        hold_n      = data_in;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        // dout is registered from the next shifter contents so it leaves a flop directly.
        head        = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];
        dout_n      = (state_n == ST_SHIFT) ? head : IDLE_BIT;
        bit_valid_n = (state_n == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            dout_q      <= IDLE_BIT;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            shreg_q     <= shreg_n;
            hold_q      <= hold_n;
            hold_full_q <= hold_full_n;
            cnt_q       <= cnt_n;
            dout_q      <= dout_n;
            bit_valid_q <= bit_valid_n;
        end
    end

    assign data_ready = !hold_full_q;
    assign busy       = (state_q == ST_SHIFT) || hold_full_q;
    assign dout       = dout_q;
    assign bit_valid  = bit_valid_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a bit-queue model, plus literal bit-pattern checks.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         ready_m, dout_m, bv_m, busy_m;
    logic         ready_l, dout_l, bv_l, busy_l;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model: queue of bits still to appear on dout; element 0 is the bit currently shown.
    bit qm[$];
    bit ql[$];
    bit acc_last = 1'b0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_m), .dout(dout_m), .bit_valid(bv_m), .busy(busy_m)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_l), .dout(dout_l), .bit_valid(bv_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm.delete();
            ql.delete();
            acc_last = 1'b0;
        end else begin
            bit acc;
            acc = data_valid && (qm.size() <= W);
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(data_in[W-1-i]);
                    ql.push_back(data_in[i]);
                end
            end
            acc_last = acc;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit nonempty;
            nonempty = (qm.size() > 0);
            chk("dout_msb",  dout_m,  nonempty ? qm[0] : 1'b0);
            chk("dout_lsb",  dout_l,  nonempty ? ql[0] : 1'b0);
            chk("bv_msb",    bv_m,    nonempty);
            chk("bv_lsb",    bv_l,    nonempty);
            chk("ready_msb", ready_m, qm.size() <= W);
            chk("ready_lsb", ready_l, qm.size() <= W);
            chk("busy_msb",  busy_m,  nonempty);
            chk("busy_lsb",  busy_l,  nonempty);
        end
    end

    // Offer one word for one cycle from idle, then collect the next 8 dout bits of each instance.
    task automatic single_word(input logic [W-1:0] w, output logic [W-1:0] got_m, output logic [W-1:0] got_l);
        @(negedge clk);
        data_in = w;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in = $urandom;
        got_m = '0;
        got_l = '0;
        for (int i = 0; i < W; i++) begin
            got_m = {got_m[W-2:0], dout_m};
            got_l = {got_l[W-2:0], dout_l};
            @(negedge clk);
        end
    endtask

    // Stream words with data_valid held, collecting payload bits; gaps counts 1->0->1 breaks in bit_valid.
    task automatic stream(input logic [3*W-1:0] words, input int nwords, input bit pulse_ff,
                          output logic [3*W-1:0] bits, output int nbits, output int gaps);
        int idx;
        bit seen_end;
        bit prev_bv;
        idx = 0;
        nbits = 0;
        gaps = 0;
        seen_end = 1'b0;
        prev_bv = 1'b0;
        bits = '0;
        @(negedge clk);
        data_in = words[3*W-1 -: W];
        data_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bv_m) begin
                if (seen_end) gaps++;
                bits = {bits[3*W-2:0], dout_m};
                nbits++;
            end else if (prev_bv) begin
                seen_end = 1'b1;
            end
            prev_bv = bv_m;
            if (acc_last) idx++;
            if (idx >= nwords) begin
                if (pulse_ff && !ready_m && c < 12) begin
                    data_in = 8'hFF;
                    data_valid = 1'b1;
                end else begin
                    data_valid = 1'b0;
                    data_in = $urandom;
                end
            end else begin
                data_in = words[3*W-1-idx*W -: W];
            end
        end
        data_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0]   gm, gl;
        logic [3*W-1:0] sbits;
        logic [3*W-1:0] words;
        int nb, gp, accepted, cyc;

        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk("rst_dout", dout_m, 1'b0);
        chk("rst_bv", bv_m, 1'b0);
        chk("rst_ready", ready_m, 1'b1);
        chk("rst_busy", busy_m, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word both bit orders; then idle outputs.
        single_word(8'hB6, gm, gl);
        chk("t1_msb_bits", gm, 8'hB6);
        chk("t5_lsb_bits", gl, 8'h6D);
        chk("t1_after_bv", bv_m, 1'b0);
        chk("t1_after_dout", dout_m, 1'b0);
        chk("t1_after_busy", busy_m, 1'b0);

        // Back-to-back stream, then same with a rejected FF offered while hold is full.
        words = 24'hB60FA5;
        stream(words, 3, 1'b0, sbits, nb, gp);
        chk("t2_nbits", nb, 24);
        chk("t2_bits", sbits, 24'hB60FA5);
        chk("t2_gaps", gp, 0);
        words = {8'hB6, 8'h0F, 8'h00};
        stream(words, 2, 1'b1, sbits, nb, gp);
        chk("t3_nbits", nb, 16);
        chk("t3_bits", sbits[15:0], 16'hB60F);
        chk("t3_gaps", gp, 0);
        repeat (4) @(negedge clk);

        // Async reset at bit 3 of B6 with 0F held.
        @(negedge clk);
        data_in = 8'hB6;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h0F;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_pre_busy", busy_m, 1'b1);
        chk("t4_pre_ready", ready_m, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_dout", dout_m, 1'b0);
        chk("t4_rst_bv", bv_m, 1'b0);
        chk("t4_rst_busy", busy_m, 1'b0);
        chk("t4_rst_ready", ready_m, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        single_word(8'h81, gm, gl);
        chk("t4_81_msb", gm, 8'h81);
        chk("t4_81_lsb", gl, 8'h81);

        // Random stream of 200 words, checked cycle by cycle against the model.
        accepted = 0;
        cyc = 0;
        while (accepted < 200 && cyc < 20000) begin
            @(negedge clk);
            if (acc_last) accepted++;
            data_valid = ($urandom_range(0, 9) < 8);
            data_in = $urandom;
            cyc++;
        end
        data_valid = 1'b0;
        chk("t6_accepted_200", accepted >= 200, 1'b1);
        repeat (3 * W) @(negedge clk);
        chk("t6_drained", busy_m, 1'b0);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
